// File: rtl/ts_pkg.sv
// Shared definitions for the TS packet path: packet length, PID index layout
// and the read-side FSM encoding used by the packet output stage.
package ts_pkg;

    localparam int TS_PKT_LEN  = 188;
    localparam int PID_INDEX_W = 12;

    // Field layout of pid_index: [11:8] except_idx, [7] descram, [6:0] match_idx.
    typedef struct packed {
        logic [3:0] except_idx;
        logic       descram;
        logic [6:0] match_idx;
    } pid_index_t;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'b001,
        RD_PRIME = 3'b010,
        RD_SEND  = 3'b100
    } rd_state_e;

endpackage

// File: rtl/pkt_dpram.sv
// Simple dual-port byte RAM with a registered read port (1-cycle latency).
// Kept as its own module so a vendor block RAM can be dropped in.
module pkt_dpram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array and read register carry no reset so this maps onto block RAM;
    // the consumer masks rdata until a read has actually been issued.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/filter_pkt_out.sv
// Ping-pong packet buffer behind the PID filter: captures each TS packet,
// commits or discards it on filter_eop, and replays committed packets on a valid/ready stream.
module filter_pkt_out
    import ts_pkg::*;
#(
    parameter int PKT_LEN    = TS_PKT_LEN,
    parameter int ADDR_W     = 9,
    parameter int DROP_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ts_valid,
    input  logic [7:0]             ts_data,
    input  logic                   ts_sop,
    input  logic [ADDR_W-1:0]      dram_waddr,
    input  logic                   filter_eop,
    input  logic                   pid_find,
    input  logic [PID_INDEX_W-1:0] pid_index,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [PID_INDEX_W-1:0] out_index,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int               OFF_W    = ADDR_W - 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PKT_LEN - 1);

    rd_state_e              state_q, state_d;
    logic [1:0]             bank_full_q, bank_full_d;
    pid_index_t [1:0]       idx_q, idx_d;
    logic                   wr_drop_q, wr_drop_d;
    logic                   older_q, older_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [OFF_W-1:0]       rd_off_q, rd_off_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic                   wr_bank;
    logic                   sop_in;
    logic                   ram_we;
    logic                   ram_re;
    logic [ADDR_W-1:0]      ram_raddr;
    logic [7:0]             ram_rdata;
    logic                   rd_clear;
    logic                   last_beat;

    assign wr_bank = dram_waddr[ADDR_W-1];
    assign sop_in  = ts_valid & ts_sop;

    // The sop byte itself must already see the new guard, so use the
    // combinational value on that cycle rather than the registered one.
    assign wr_drop_d = sop_in ? bank_full_q[wr_bank] : wr_drop_q;
    assign ram_we    = ts_valid & ~wr_drop_d;

    pkt_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (dram_waddr),
        .wdata (ts_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: every always_comb assigns all of its outputs a default first so no latch is inferred.
    always_comb begin
        bank_full_d = bank_full_q;
        idx_d       = idx_q;
        older_d     = older_q;
        drop_cnt_d  = drop_cnt_q;

        if (rd_clear) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end

        if (filter_eop && pid_find) begin
            if (!wr_drop_q) begin
                bank_full_d[wr_bank] = 1'b1;
                idx_d[wr_bank]       = pid_index;
                if (bank_full_q[~wr_bank]) begin
                    older_d = ~wr_bank;
                end
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_off_d  = rd_off_q;
        ram_re    = 1'b0;
        ram_raddr = {rd_bank_q, rd_off_q};
        rd_clear  = 1'b0;
        last_beat = (rd_off_q == LAST_OFF);
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;

        unique case (state_q)
            RD_IDLE: begin
                if (|bank_full_q) begin
                    rd_bank_d = (&bank_full_q) ? older_q : bank_full_q[1];
                    rd_off_d  = '0;
                    state_d   = RD_PRIME;
                end
            end
            RD_PRIME: begin
                ram_re    = 1'b1;
                ram_raddr = {rd_bank_q, {OFF_W{1'b0}}};
                state_d   = RD_SEND;
            end
            RD_SEND: begin
                out_valid = 1'b1;
                out_sop   = (rd_off_q == '0);
                out_eop   = last_beat;
                // On a stall neither the address nor the read register moves.
                if (out_ready) begin
                    if (last_beat) begin
                        rd_clear = 1'b1;
                        state_d  = RD_IDLE;
                    end else begin
                        rd_off_d  = rd_off_q + OFF_W'(1);
                        ram_re    = 1'b1;
                        ram_raddr = {rd_bank_q, rd_off_d};
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    assign out_data  = (state_q == RD_SEND) ? ram_rdata : 8'h00;
    assign out_index = idx_q[rd_bank_q];
    assign drop_cnt  = drop_cnt_q;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            bank_full_q <= '0;
            idx_q       <= '0;
            wr_drop_q   <= 1'b0;
            older_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_off_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            idx_q       <= idx_d;
            wr_drop_q   <= wr_drop_d;
            older_q     <= older_d;
            rd_bank_q   <= rd_bank_d;
            rd_off_q    <= rd_off_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_filter_pkt_out.sv
// Randomised bench for filter_pkt_out: a packet-level scoreboard tracks which
// banks hold unsent packets and the byte stream each committed packet must produce.
module tb_filter_pkt_out;

    localparam int PKT_LEN = 188;

    logic        clk = 1'b0;
    logic        rst;
    logic        ts_valid;
    logic [7:0]  ts_data;
    logic        ts_sop;
    logic [8:0]  dram_waddr;
    logic        filter_eop;
    logic        pid_find;
    logic [11:0] pid_index;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic [11:0] out_index;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    filter_pkt_out dut (
        .clk        (clk),
        .rst        (rst),
        .ts_valid   (ts_valid),
        .ts_data    (ts_data),
        .ts_sop     (ts_sop),
        .dram_waddr (dram_waddr),
        .filter_eop (filter_eop),
        .pid_find   (pid_find),
        .pid_index  (pid_index),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_index  (out_index),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic [11:0] idx;
        logic        bank;
    } beat_t;

    beat_t exp_q[$];
    bit    bank_busy [2];
    int    checks     = 0;
    int    errors     = 0;
    int    exp_drop   = 0;
    int    cyc        = 0;
    int    beats_out  = 0;
    int    ready_mode = 0;
    int    commit_cyc = 0;
    bit    lat_armed  = 1'b0;
    bit    prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: held high, held low, or random (about 2/3 high).
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Output monitor: every presented beat, stalled or not, must equal the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prev_valid && lat_armed) begin
                    check("latency", cyc - commit_cyc, 3);
                    lat_armed = 1'b0;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", 32'(out_valid), 0);
                    end else begin
                        check("data",  32'(out_data),  32'(exp_q[0].data));
                        check("sop",   32'(out_sop),   32'(exp_q[0].sop));
                        check("eop",   32'(out_eop),   32'(exp_q[0].eop));
                        check("index", 32'(out_index), 32'(exp_q[0].idx));
                        if (out_ready) begin
                            if (exp_q[0].eop) begin
                                bank_busy[exp_q[0].bank] = 1'b0;
                                beats_out = 0;
                            end else begin
                                beats_out++;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
            prev_valid = rst ? 1'b0 : out_valid;
        end
    end

    task automatic send_pkt(input logic bank, input logic find, input logic [11:0] idx,
                            input bit rnd, input int gap);
        logic [7:0] b [PKT_LEN];
        bit         drop = 1'b0;
        for (int i = 0; i < PKT_LEN; i++) begin
            if (rnd)       b[i] = 8'($urandom);
            else if (i < 3) b[i] = 8'h00;
            else           b[i] = 8'(i);
        end
        b[0] = 8'h47;
        if (!rnd) b[1] = 8'h01;
        for (int i = 0; i < PKT_LEN; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) drop = bank_busy[bank];
            ts_valid   = 1'b1;
            ts_sop     = (i == 0);
            ts_data    = b[i];
            dram_waddr = {bank, 8'(i)};
        end
        @(posedge clk);
        #1;
        ts_valid   = 1'b0;
        ts_sop     = 1'b0;
        filter_eop = 1'b1;
        pid_find   = find;
        pid_index  = idx;
        if (find && drop) begin
            exp_drop++;
        end else if (find) begin
            if (exp_q.size() == 0) begin
                lat_armed  = 1'b1;
                commit_cyc = cyc;
            end
            bank_busy[bank] = 1'b1;
            for (int i = 0; i < PKT_LEN; i++)
                exp_q.push_back('{data: b[i], sop: (i == 0), eop: (i == PKT_LEN - 1), idx: idx, bank: bank});
        end
        @(posedge clk);
        #1;
        filter_eop = 1'b0;
        pid_find   = 1'($urandom);
        pid_index  = 12'($urandom);
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        ts_valid   = 1'b0;
        ts_data    = 8'h00;
        ts_sop     = 1'b0;
        dram_waddr = 9'h000;
        filter_eop = 1'b0;
        pid_find   = 1'b0;
        pid_index  = 12'h000;
        bank_busy  = '{1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data),  0);
        check("rst_sop",   32'(out_sop),   0);
        check("rst_eop",   32'(out_eop),   0);
        check("rst_index", 32'(out_index), 0);
        check("rst_drop",  32'(drop_cnt),  0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single match with the reference byte pattern.
        ready_mode = 0;
        send_pkt(1'b0, 1'b1, 12'h283, 1'b0, 3);
        drain("single_drain");
        check("single_drop", 32'(drop_cnt), exp_drop);

        // Non-match leaves the output idle; the bank is then reused.
        send_pkt(1'b0, 1'b0, 12'h3ff, 1'b1, 3);
        repeat (6) @(posedge clk);
        #1;
        check("nomatch_idle", 32'(out_valid), 0);
        send_pkt(1'b0, 1'b1, 12'h011, 1'b1, 3);
        drain("reuse_drain");

        // Back-to-back matches into both banks with the minimum gap.
        send_pkt(1'b0, 1'b1, 12'h081, 1'b1, 3);
        send_pkt(1'b1, 1'b1, 12'h102, 1'b1, 3);
        drain("b2b_drain");
        check("b2b_drop", 32'(drop_cnt), exp_drop);

        // Overflow under full backpressure: the third packet is dropped.
        ready_mode = 1;
        send_pkt(1'b0, 1'b1, 12'h201, 1'b1, 3);
        send_pkt(1'b1, 1'b1, 12'h202, 1'b1, 3);
        send_pkt(1'b0, 1'b1, 12'h203, 1'b1, 3);
        check("ovf_drop", 32'(drop_cnt), exp_drop);
        check("ovf_drop_one", 32'(drop_cnt), 1);
        ready_mode = 0;
        drain("ovf_drain");

        // Random traffic with random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 14; k++)
            send_pkt(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 12'($urandom),
                     1'b1, int'($urandom_range(3, 12)));
        drain("rand_drain");
        check("rand_drop", 32'(drop_cnt), exp_drop);

        // Asynchronous reset in the middle of a packet at beat 50.
        ready_mode = 0;
        send_pkt(1'b1, 1'b1, 12'h3a5, 1'b1, 3);
        n = 0;
        while (beats_out != 50 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("rst_wait", beats_out, 50);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data",  32'(out_data),  0);
        check("mid_rst_sop",   32'(out_sop),   0);
        check("mid_rst_eop",   32'(out_eop),   0);
        check("mid_rst_index", 32'(out_index), 0);
        check("mid_rst_drop",  32'(drop_cnt),  0);
        exp_q.delete();
        bank_busy = '{1'b0, 1'b0};
        exp_drop  = 0;
        lat_armed = 1'b0;
        beats_out = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_pkt(1'b1, 1'b1, 12'h155, 1'b1, 3);
        drain("post_rst_drain");
        check("post_rst_drop", 32'(drop_cnt), exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
